// File: rtl/hazard_forward_unit.sv
// Hazard detection and ALU forwarding control for the 5-stage pipeline.
// Tracks one in-flight mul/div result and counts stall cycles.
module hazard_forward_unit #(
  parameter int AW         = 5,
  parameter int NUM_SRC    = 2,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC*AW-1:0]  id_src_addr,
  input  logic                   id_is_muldiv,
  input  logic                   dx_valid,
  input  logic [NUM_SRC*AW-1:0]  dx_src_addr,
  input  logic [AW-1:0]          dx_dest_addr,
  input  logic                   dx_is_load,
  input  logic                   dx_is_muldiv,
  input  logic                   write_reg_xm,
  input  logic [AW-1:0]          write_reg_addr_xm,
  input  logic                   write_reg_mw,
  input  logic [AW-1:0]          write_reg_addr_mw,
  input  logic                   stat_clr,
  output logic [2*NUM_SRC-1:0]   fwd_sel,
  output logic                   stall,
  output logic                   bubble_dx,
  output logic                   muldiv_busy,
  output logic [CNT_W-1:0]       stall_count
);

  localparam int CLOG = $clog2(MULDIV_LAT + 1);
  localparam int CW   = (CLOG < 3) ? 3 : CLOG;

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          pend_q, pend_d;
  logic [CNT_W-1:0]       sc_q, sc_d;
  logic [2*NUM_SRC-1:0]   fwd;
  logic                   busy;
  logic                   lu_hit;
  logic                   raw_hit;
  logic                   lu_hz;
  logic                   raw_hz;
  logic                   st_hz;
  logic                   hz;

  always_comb begin
    fwd     = '0;
    lu_hit  = 1'b0;
    raw_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (write_reg_xm && write_reg_addr_xm != '0 &&
          write_reg_addr_xm == dx_src_addr[i*AW +: AW])
        fwd[2*i +: 2] = 2'b10;
      else if (write_reg_mw && write_reg_addr_mw != '0 &&
               write_reg_addr_mw == dx_src_addr[i*AW +: AW])
        fwd[2*i +: 2] = 2'b01;
      if (dx_dest_addr == id_src_addr[i*AW +: AW])
        lu_hit = 1'b1;
      if (pend_q == id_src_addr[i*AW +: AW])
        raw_hit = 1'b1;
    end
  end

  assign busy   = (cnt_q != '0);
  assign lu_hz  = dx_valid && dx_is_load &&
                  (dx_dest_addr != '0) && lu_hit;
  assign raw_hz = busy && (pend_q != '0) && raw_hit;
  assign st_hz  = busy && id_is_muldiv;
  assign hz     = lu_hz || raw_hz || st_hz;

  // Outputs read as idle for the whole reset window
  assign fwd_sel     = rst ? '0 : fwd;
  assign stall       = !rst && hz;
  assign bubble_dx   = !rst && hz;
  assign muldiv_busy = !rst && busy;
  assign stall_count = sc_q;

  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (dx_valid && dx_is_muldiv) begin
      cnt_d  = CW'(MULDIV_LAT);
      pend_d = dx_dest_addr;
    end else if (busy) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    sc_d = sc_q;
    if (stat_clr)
      sc_d = '0;
    else if (hz && !(&sc_q))
      sc_d = sc_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pend_q <= '0;
      sc_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      sc_q   <= sc_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: directed scenarios,
// then random traffic against a cycle-indexed reference model.
module tb_hazard_forward_unit;

  localparam int AW  = 5;
  localparam int NS  = 2;
  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  typedef struct packed {
    logic [2*NS-1:0] fwd;
    logic            stall;
    logic            bub;
    logic            busy;
    logic [CW-1:0]   cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS*AW-1:0]  id_src_addr;
  logic              id_is_muldiv;
  logic              dx_valid;
  logic [NS*AW-1:0]  dx_src_addr;
  logic [AW-1:0]     dx_dest_addr;
  logic              dx_is_load;
  logic              dx_is_muldiv;
  logic              write_reg_xm;
  logic [AW-1:0]     write_reg_addr_xm;
  logic              write_reg_mw;
  logic [AW-1:0]     write_reg_addr_mw;
  logic              stat_clr;
  logic [2*NS-1:0]   fwd_sel;
  logic              stall;
  logic              bubble_dx;
  logic              muldiv_busy;
  logic [CW-1:0]     stall_count;

  hazard_forward_unit #(
    .AW(AW), .NUM_SRC(NS), .MULDIV_LAT(LAT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .id_src_addr(id_src_addr), .id_is_muldiv(id_is_muldiv),
    .dx_valid(dx_valid), .dx_src_addr(dx_src_addr),
    .dx_dest_addr(dx_dest_addr), .dx_is_load(dx_is_load),
    .dx_is_muldiv(dx_is_muldiv),
    .write_reg_xm(write_reg_xm), .write_reg_addr_xm(write_reg_addr_xm),
    .write_reg_mw(write_reg_mw), .write_reg_addr_mw(write_reg_addr_mw),
    .stat_clr(stat_clr),
    .fwd_sel(fwd_sel), .stall(stall), .bubble_dx(bubble_dx),
    .muldiv_busy(muldiv_busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 0;

  // Reference state: mul/div result is outstanding while cyc < done_cyc
  int   cyc      = 0;
  int   done_cyc = 0;
  int   pend     = 0;
  int   sc       = 0;

  function automatic int src(input logic [NS*AW-1:0] v, input int i);
    return int'(v[i*AW +: AW]);
  endfunction

  task automatic model_cycle();
    exp_t e;
    bit   any_ld, any_pd, lu, raw, st, bz;
    #1;
    e = '0;
    if (!rst) begin
      for (int i = 0; i < NS; i++) begin
        int s = src(dx_src_addr, i);
        if (write_reg_xm && write_reg_addr_xm != 0 && int'(write_reg_addr_xm) == s)
          e.fwd[2*i +: 2] = 2'b10;
        else if (write_reg_mw && write_reg_addr_mw != 0 && int'(write_reg_addr_mw) == s)
          e.fwd[2*i +: 2] = 2'b01;
      end
      any_ld = 0;
      any_pd = 0;
      for (int i = 0; i < NS; i++) begin
        if (src(id_src_addr, i) == int'(dx_dest_addr)) any_ld = 1;
        if (src(id_src_addr, i) == pend) any_pd = 1;
      end
      bz  = (cyc < done_cyc);
      lu  = dx_valid && dx_is_load && dx_dest_addr != 0 && any_ld;
      raw = bz && pend != 0 && any_pd;
      st  = bz && id_is_muldiv;
      e.stall = lu || raw || st;
      e.bub   = e.stall;
      e.busy  = bz;
      e.cnt   = CW'(sc);
    end
    q.push_back(e);
    if (rst) begin
      done_cyc = 0;
      pend     = 0;
      sc       = 0;
    end else begin
      if (stat_clr) sc = 0;
      else if (e.stall && sc < SAT) sc++;
      if (dx_valid && dx_is_muldiv) begin
        done_cyc = cyc + 1 + LAT;
        pend     = int'(dx_dest_addr);
      end
    end
    cyc++;
  endtask

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("fwd_sel", int'(fwd_sel), int'(e.fwd));
        check("stall", int'(stall), int'(e.stall));
        check("bubble_dx", int'(bubble_dx), int'(e.bub));
        check("muldiv_busy", int'(muldiv_busy), int'(e.busy));
        check("stall_count", int'(stall_count), int'(e.cnt));
      end
    end
  end

  task automatic idle();
    rst = 0; id_src_addr = '0; id_is_muldiv = 0;
    dx_valid = 0; dx_src_addr = '0; dx_dest_addr = '0;
    dx_is_load = 0; dx_is_muldiv = 0;
    write_reg_xm = 0; write_reg_addr_xm = '0;
    write_reg_mw = 0; write_reg_addr_mw = '0;
    stat_clr = 0;
  endtask

  task automatic step();
    model_cycle();
    @(negedge clk);
  endtask

  task automatic dx_mul(input logic [AW-1:0] d);
    dx_valid = 1; dx_is_muldiv = 1; dx_dest_addr = d;
    step();
    dx_valid = 0; dx_is_muldiv = 0; dx_dest_addr = '0;
  endtask

  initial begin : stim
    idle();
    rst = 1;
    @(negedge clk);
    step();
    step();
    rst = 0;
    step();

    // Forwarding priority, then XM address 0 falls back to MW
    write_reg_xm = 1; write_reg_addr_xm = 5;
    write_reg_mw = 1; write_reg_addr_mw = 5;
    dx_src_addr = {5'd7, 5'd5};
    step();
    write_reg_addr_xm = 0;
    step();
    idle();

    // Load-use for a single cycle
    dx_valid = 1; dx_is_load = 1; dx_dest_addr = 3;
    id_src_addr = {5'd3, 5'd1};
    step();
    dx_valid = 0;
    step();
    idle();

    // Mul/div RAW on r9
    dx_mul(9);
    id_src_addr = {5'd0, 5'd9};
    repeat (6) step();
    idle();

    // Structural: second mul waits, then captures
    dx_mul(4);
    id_is_muldiv = 1;
    repeat (5) step();
    id_is_muldiv = 0;
    dx_mul(6);
    repeat (5) step();

    // Saturation, then clear while stalled
    dx_valid = 1; dx_is_load = 1; dx_dest_addr = 3;
    id_src_addr = {5'd3, 5'd3};
    repeat (20) step();
    stat_clr = 1;
    step();
    stat_clr = 0;
    step();
    idle();

    // Reset mid-operation drops the pending entry
    dx_mul(9);
    repeat (2) step();
    id_src_addr = {5'd9, 5'd9};
    rst = 1;
    step();
    rst = 0;
    repeat (3) step();
    idle();

    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 199) == 0);
      id_src_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_is_muldiv = ($urandom_range(0, 3) == 0);
      dx_valid     = ($urandom_range(0, 3) != 0);
      dx_src_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      dx_dest_addr = 5'($urandom_range(0, 7));
      dx_is_load   = ($urandom_range(0, 2) == 0);
      dx_is_muldiv = !dx_is_load && ($urandom_range(0, 6) == 0);
      write_reg_xm = $urandom_range(0, 1) == 1;
      write_reg_addr_xm = 5'($urandom_range(0, 7));
      write_reg_mw = $urandom_range(0, 1) == 1;
      write_reg_addr_mw = 5'($urandom_range(0, 7));
      stat_clr     = ($urandom_range(0, 29) == 0);
      step();
    end
    idle();

    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
